// File: rtl/rd_sched_if.sv
// Descriptor, issue-handshake and status signals of the packet-read scheduler.
// The master side feeds descriptors and models rd_ctrl; the slave side is the scheduler.
interface rd_sched_if #(
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          desc_valid;
  logic [31:0]   desc_begin;
  logic [31:0]   desc_end;
  logic          desc_ready;
  logic          enable;
  logic          rd_ctrl;
  logic [31:0]   pkt_begin;
  logic [31:0]   pkt_end;
  logic [31:0]   control;
  logic          rd_ctrl_rdy;
  logic          pkt_done;
  logic [LW-1:0] queue_level;
  logic [15:0]   drop_cnt;
  logic          timeout_err;
  logic          busy;

  modport master (
    output desc_valid, desc_begin, desc_end, enable, rd_ctrl_rdy,
    input  desc_ready, rd_ctrl, pkt_begin, pkt_end, control, pkt_done,
           queue_level, drop_cnt, timeout_err, busy
  );

  modport slave (
    input  desc_valid, desc_begin, desc_end, enable, rd_ctrl_rdy,
    output desc_ready, rd_ctrl, pkt_begin, pkt_end, control, pkt_done,
           queue_level, drop_cnt, timeout_err, busy
  );
endinterface

// File: rtl/rd_sched.sv
// Packet-read scheduler: validates and queues descriptors, then issues them in
// arrival order to rd_ctrl, counting drops and flagging unaccepted requests.
module rd_sched #(
  parameter int DEPTH       = 8,
  parameter int MAX_LEN     = 2048,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic      clk,
  input  logic      reset,
  rd_sched_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RUN} state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_mem_begin [DEPTH];
  logic [31:0]   r_mem_end   [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_count;
  logic [TW-1:0] r_tcnt;
  logic [15:0]   r_seq, r_control, r_drop;
  logic [31:0]   r_pkt_begin, r_pkt_end;
  logic          r_rd_ctrl, r_done, r_to_err;

  logic [31:0]   w_len;
  logic          w_desc_ok, w_full, w_empty, w_push, w_drop;
  logic          w_pop, w_ack, w_timeout, w_done;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_len     = bus.desc_end - bus.desc_begin;
  assign w_desc_ok = (bus.desc_begin[1:0] == 2'b00) && (bus.desc_end[1:0] == 2'b00) &&
                     (bus.desc_end > bus.desc_begin) && (w_len <= 32'(MAX_LEN));
  // Fullness uses registered occupancy, so a same-cycle pop cannot make room.
  assign w_full    = (r_count == LW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push    = bus.desc_valid && w_desc_ok && !w_full;
  assign w_drop    = bus.desc_valid && !w_push;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_ack       = 1'b0;
    w_timeout   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: if (bus.enable && !w_empty && bus.rd_ctrl_rdy) begin
        w_pop       = 1'b1;
        w_state_nxt = ISSUE;
      end
      ISSUE: if (!bus.rd_ctrl_rdy) begin
        w_ack       = 1'b1;
        w_state_nxt = RUN;
      end else if (r_tcnt == TW'(ACK_TIMEOUT)) begin
        w_timeout   = 1'b1;
        w_state_nxt = IDLE;
      end
      RUN: if (bus.rd_ctrl_rdy) begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_tcnt      <= '0;
      r_seq       <= '0;
      r_control   <= '0;
      r_drop      <= '0;
      r_pkt_begin <= '0;
      r_pkt_end   <= '0;
      r_rd_ctrl   <= 1'b0;
      r_done      <= 1'b0;
      r_to_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done;
      if (w_pop) begin
        r_rd_ctrl   <= 1'b1;
        r_tcnt      <= '0;
        r_pkt_begin <= r_mem_begin[r_rptr];
        r_pkt_end   <= r_mem_end[r_rptr];
        r_control   <= r_seq;
        r_rptr      <= r_rptr + 1'b1;
      end else if (w_ack || w_timeout) begin
        r_rd_ctrl <= 1'b0;
      end else if (r_state == ISSUE) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
      if (w_timeout) r_to_err <= 1'b1;
      if (w_timeout || w_done) r_seq <= r_seq + 16'd1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_push && !w_pop) r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (w_drop) r_drop <= sat_inc16(r_drop);
    end
  end

  // Queue storage carries no reset; occupancy and pointers define what is live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_begin[r_wptr] <= bus.desc_begin;
      r_mem_end[r_wptr]   <= bus.desc_end;
    end
  end

  assign bus.desc_ready  = !w_full;
  assign bus.queue_level = r_count;
  assign bus.rd_ctrl     = r_rd_ctrl;
  assign bus.pkt_begin   = r_pkt_begin;
  assign bus.pkt_end     = r_pkt_end;
  assign bus.control     = {16'd0, r_control};
  assign bus.pkt_done    = r_done;
  assign bus.drop_cnt    = r_drop;
  assign bus.timeout_err = r_to_err;
  assign bus.busy        = (r_state != IDLE);
endmodule

// File: tb/tb_rd_sched.sv
// Bench for rd_sched: directed scenarios plus random traffic, compared every
// cycle against a queue-based reference model of the scheduler's rules.
module tb_rd_sched;
  localparam int DEPTH       = 8;
  localparam int MAX_LEN     = 2048;
  localparam int ACK_TIMEOUT = 255;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rd_sched_if #(.DEPTH(DEPTH)) bus();

  rd_sched #(.DEPTH(DEPTH), .MAX_LEN(MAX_LEN), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {logic [31:0] b; logic [31:0] e;} desc_t;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  desc_t       mq[$];
  int          m_phase;
  int          m_wait;
  int          m_seq;
  int          m_drop;
  logic        m_rd, m_done, m_terr;
  logic [31:0] m_pb, m_pe, m_ctl;

  // Observed-event bookkeeping
  int          rises, dones, rd_hi, run_age;
  logic        prev_rd;
  logic [31:0] ctl_log[$];
  logic [31:0] beg_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit desc_ok(input logic [31:0] b, input logic [31:0] e);
    return (b[1:0] == 2'b00) && (e[1:0] == 2'b00) && (e > b) && ((e - b) <= 32'(MAX_LEN));
  endfunction

  function automatic logic [31:0] log_at(input int which, input int i);
    if (which == 0) return (i < ctl_log.size()) ? ctl_log[i] : 32'hFFFF_FFFF;
    return (i < beg_log.size()) ? beg_log[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_phase = 0; m_wait = 0; m_seq = 0; m_drop = 0;
    m_rd = 1'b0; m_done = 1'b0; m_terr = 1'b0;
    m_pb = '0; m_pe = '0; m_ctl = '0;
  endtask

  // One clock edge of the reference: pop/issue decisions see the pre-edge queue.
  task automatic model_edge();
    bit    full;
    bit    take;
    desc_t d;
    full   = (mq.size() == DEPTH);
    take   = bus.desc_valid && desc_ok(bus.desc_begin, bus.desc_end) && !full;
    m_done = 1'b0;
    case (m_phase)
      0: if (bus.enable && mq.size() != 0 && bus.rd_ctrl_rdy) begin
        d = mq.pop_front();
        m_pb = d.b; m_pe = d.e; m_ctl = 32'(m_seq);
        m_rd = 1'b1; m_wait = 0; m_phase = 1;
      end
      1: if (!bus.rd_ctrl_rdy) begin
        m_rd = 1'b0; m_phase = 2;
      end else if (m_wait == ACK_TIMEOUT) begin
        m_rd = 1'b0; m_terr = 1'b1; m_seq = (m_seq + 1) % 65536; m_phase = 0;
      end else begin
        m_wait++;
      end
      default: if (bus.rd_ctrl_rdy) begin
        m_done = 1'b1; m_seq = (m_seq + 1) % 65536; m_phase = 0;
      end
    endcase
    if (take) mq.push_back('{b: bus.desc_begin, e: bus.desc_end});
    else if (bus.desc_valid && m_drop < 65535) m_drop++;
  endtask

  task automatic compare_all();
    check("rd_ctrl",     32'(bus.rd_ctrl),     32'(m_rd));
    check("pkt_begin",   bus.pkt_begin,        m_pb);
    check("pkt_end",     bus.pkt_end,          m_pe);
    check("control",     bus.control,          m_ctl);
    check("pkt_done",    32'(bus.pkt_done),    32'(m_done));
    check("queue_level", 32'(bus.queue_level), 32'(mq.size()));
    check("desc_ready",  32'(bus.desc_ready),  32'(mq.size() != DEPTH));
    check("drop_cnt",    32'(bus.drop_cnt),    32'(m_drop));
    check("timeout_err", 32'(bus.timeout_err), 32'(m_terr));
    check("busy",        32'(bus.busy),        32'(m_phase != 0));
    if (bus.rd_ctrl === 1'b1 && prev_rd !== 1'b1) begin
      rises++;
      ctl_log.push_back(bus.control);
      beg_log.push_back(bus.pkt_begin);
    end
    if (bus.rd_ctrl === 1'b1) rd_hi++;
    if (bus.pkt_done === 1'b1) dones++;
    prev_rd = bus.rd_ctrl;
  endtask

  task automatic clr_obs();
    rises = 0; dones = 0; rd_hi = 0; run_age = 0;
    ctl_log.delete();
    beg_log.delete();
  endtask

  task automatic step(input logic v, input logic [31:0] b, input logic [31:0] e,
                      input logic en, input logic rdy);
    @(negedge clk);
    bus.desc_valid  = v;
    bus.desc_begin  = b;
    bus.desc_end    = e;
    bus.enable      = en;
    bus.rd_ctrl_rdy = rdy;
    @(posedge clk);
    model_edge();
    #1 compare_all();
  endtask

  // rd_ctrl stand-in: accepts one cycle after the request, finishes 8 cycles later
  function automatic logic det_rdy();
    if (m_phase == 1) return 1'b0;
    if (m_phase == 2) begin
      run_age++;
      return (run_age >= 8);
    end
    run_age = 0;
    return 1'b1;
  endfunction

  task automatic push(input logic [31:0] b, input logic [31:0] e, input logic en);
    step(1'b1, b, e, en, det_rdy());
  endtask

  task automatic idle(input int n, input logic en);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, en, det_rdy());
  endtask

  task automatic rst_assert();
    @(negedge clk);
    #2;
    reset = 1'b1;
    bus.desc_valid = 1'b0;
    model_reset();
    #1 compare_all();
  endtask

  task automatic rst_release();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_reset();
    rst_assert();
    rst_release();
    clr_obs();
  endtask

  initial begin
    bus.desc_valid  = 1'b0;
    bus.desc_begin  = '0;
    bus.desc_end    = '0;
    bus.enable      = 1'b0;
    bus.rd_ctrl_rdy = 1'b1;
    prev_rd         = 1'b0;
    model_reset();
    clr_obs();
    do_reset();
    check("reset_desc_ready", 32'(bus.desc_ready), 32'd1);

    // Single packet
    push(32'h0, 32'h20, 1'b1);
    check("single_rd_early", 32'(bus.rd_ctrl), 32'd0);
    idle(1, 1'b1);
    check("single_rd_lat", 32'(bus.rd_ctrl), 32'd1);
    idle(14, 1'b1);
    check("single_rises", 32'(rises), 32'd1);
    check("single_done", 32'(dones), 32'd1);
    check("single_end", bus.pkt_end, 32'h20);
    check("single_ctl", log_at(0, 0), 32'd0);
    check("single_level", 32'(bus.queue_level), 32'd0);

    // FIFO order and sequence numbers
    do_reset();
    push(32'h0, 32'h20, 1'b1);
    push(32'h40, 32'h80, 1'b1);
    push(32'h100, 32'h104, 1'b1);
    idle(50, 1'b1);
    check("fifo_rises", 32'(rises), 32'd3);
    check("fifo_done", 32'(dones), 32'd3);
    check("fifo_beg0", log_at(1, 0), 32'h0);
    check("fifo_beg1", log_at(1, 1), 32'h40);
    check("fifo_beg2", log_at(1, 2), 32'h100);
    for (int i = 0; i < 3; i++) check("fifo_ctl", log_at(0, i), 32'(i));

    // Full queue
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) push(32'(i * 64), 32'(i * 64 + 16), 1'b0);
    check("full_level", 32'(bus.queue_level), 32'd8);
    check("full_ready", 32'(bus.desc_ready), 32'd0);
    check("full_drop", 32'(bus.drop_cnt), 32'd2);
    check("full_no_issue", 32'(rises), 32'd0);
    idle(150, 1'b1);
    check("full_issues", 32'(rises), 32'd8);

    // Invalid descriptors
    do_reset();
    push(32'h20, 32'h20, 1'b1);
    push(32'h2, 32'h10, 1'b1);
    push(32'h0, 32'h1000, 1'b1);
    idle(5, 1'b1);
    check("inval_drop", 32'(bus.drop_cnt), 32'd3);
    check("inval_rises", 32'(rises), 32'd0);

    // Acceptance timeout: rd_ctrl_rdy never falls
    do_reset();
    step(1'b1, 32'h0, 32'h20, 1'b1, 1'b1);
    for (int i = 0; i < ACK_TIMEOUT + 10; i++) step(1'b0, '0, '0, 1'b1, 1'b1);
    check("to_rd_cycles", 32'(rd_hi), 32'(ACK_TIMEOUT + 1));
    check("to_err", 32'(bus.timeout_err), 32'd1);
    check("to_done", 32'(dones), 32'd0);
    check("to_drop", 32'(bus.drop_cnt), 32'd0);
    push(32'h40, 32'h60, 1'b1);
    idle(15, 1'b1);
    check("to_next_ctl", log_at(0, 1), 32'd1);

    // Reset while a request is being presented
    do_reset();
    push(32'h0, 32'h20, 1'b1);
    idle(1, 1'b1);
    check("rst_issue_pre", 32'(bus.rd_ctrl), 32'd1);
    rst_assert();
    check("rst_issue_rd", 32'(bus.rd_ctrl), 32'd0);
    rst_release();
    clr_obs();

    // Reset in RUN with two descriptors queued
    for (int i = 0; i < 3; i++) push(32'(i * 64), 32'(i * 64 + 32), 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("rst_run_busy_pre", 32'(bus.busy), 32'd1);
    check("rst_run_level_pre", 32'(bus.queue_level), 32'd2);
    rst_assert();
    check("rst_run_rd", 32'(bus.rd_ctrl), 32'd0);
    check("rst_run_busy", 32'(bus.busy), 32'd0);
    check("rst_run_level", 32'(bus.queue_level), 32'd0);
    rst_release();
    clr_obs();
    idle(20, 1'b1);
    check("rst_no_issue", 32'(rises), 32'd0);

    // Random traffic against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] b, e;
      logic        v, en, rdy;
      b = 32'($urandom_range(0, 255)) << 4;
      case ($urandom % 8)
        0:       e = b;
        1:       e = b + 32'(MAX_LEN);
        2:       e = b + 32'(MAX_LEN + 4);
        3:       e = b + 32'd3;
        4:       e = (b >= 32'd4) ? b - 32'd4 : b + 32'd8;
        default: e = b + 32'(4 * $urandom_range(1, 64));
      endcase
      if ($urandom % 10 == 0) b = b | 32'd1;
      v   = ($urandom % 3 == 0);
      en  = ($urandom % 6 != 0);
      rdy = (m_phase == 1) ? 1'($urandom % 2) :
            (m_phase == 2) ? ($urandom % 4 == 0) : ($urandom % 8 != 0);
      step(v, b, e, en, rdy);
    end
    check("rand_some_issued", 32'(rises > 50), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/rd_sched.md
# rd_sched

Packet-read scheduler in front of `rd_ctrl`. Accepts packet descriptors (byte begin/end addresses in packet memory) from the capture side and queues them. Issues them one at a time to `rd_ctrl` over its start/ready handshake, so packets are streamed back to the output FIFO in arrival order. Also validates descriptors and counts drops and packets, and flags a `rd_ctrl` that never accepts a request.

## Interface

Parameters:
- `DEPTH`, 8 — descriptor queue entries; power of two, ≥2.
- `MAX_LEN`, 2048 — maximum packet length in bytes.
- `ACK_TIMEOUT`, 255 — cycles to wait for `rd_ctrl` to accept a request.

Ports:
- `clk` in 1 — clock.
- `reset` in 1 — asynchronous, active-high reset.
- `desc_valid` in 1 — descriptor present this cycle; single-cycle strobe, no backpressure stall.
- `desc_begin` in 32 — packet start byte address.
- `desc_end` in 32 — packet end byte address, exclusive.
- `desc_ready` out 1 — queue not full.
- `enable` in 1 — allow new issues.
- `rd_ctrl` out 1 — start request to `rd_ctrl`.
- `pkt_begin` out 32 — begin address presented to `rd_ctrl`.
- `pkt_end` out 32 — end address presented to `rd_ctrl`.
- `control` out 32 — `{16'd0, seq[15:0]}`, where `seq` is the sequence number of the issued packet.
- `rd_ctrl_rdy` in 1 — `rd_ctrl` idle.
- `pkt_done` out 1 — one-cycle pulse when a packet finishes.
- `queue_level` out $clog2(DEPTH)+1 — current queue occupancy.
- `drop_cnt` out 16 — dropped descriptors; saturates at 0xFFFF.
- `timeout_err` out 1 — sticky; set on an acceptance timeout.
- `busy` out 1 — state ≠ IDLE.

## Operation

**Reset values:** all outputs 0, with one exception: `desc_ready` = 1. State = IDLE, queue empty, `seq` = 0.

**Descriptor validity:** a descriptor is valid iff all of the following hold:
- `desc_begin[1:0]` = 0 and `desc_end[1:0]` = 0;
- `desc_end` > `desc_begin` (unsigned);
- `desc_end` − `desc_begin` ≤ `MAX_LEN`.

**Push/drop:**
- Push: `desc_valid` & valid & !full → write to queue.
- Drop: `desc_valid` & (invalid | full) → `drop_cnt` += 1 (saturating); descriptor discarded.
- Full is the registered occupancy = `DEPTH`. A push while full is dropped even if a pop occurs in the same cycle.
- Simultaneous push and pop → `queue_level` unchanged.

**Queue:** circular buffer with a read and a write pointer that wrap modulo `DEPTH`.

**FSM:**
- IDLE:
  - Exit condition: `enable` & !empty & `rd_ctrl_rdy`.
  - Action: pop the head entry; register `pkt_begin`, `pkt_end`, and `control` = `seq`; `rd_ctrl` ← 1; clear the timeout counter; go to ISSUE.
- ISSUE:
  - Hold `rd_ctrl` = 1 and keep `pkt_begin`, `pkt_end`, `control` stable.
  - On `rd_ctrl_rdy` = 0: `rd_ctrl` ← 0; go to RUN.
  - Otherwise, when the counter reaches `ACK_TIMEOUT`: `rd_ctrl` ← 0; `timeout_err` ← 1; `seq` += 1; go to IDLE. The packet is lost and is not counted in `drop_cnt`.
- RUN:
  - On `rd_ctrl_rdy` = 1: `pkt_done` pulse; `seq` += 1 (wraps at 16 bits); go to IDLE.

**Enable:** deasserting `enable` never aborts a packet in ISSUE or RUN; it only blocks the IDLE → ISSUE transition.

**Address outputs:** `pkt_begin`, `pkt_end`, `control` hold their last issued values between packets.

**Reset mid-operation:** `rd_ctrl` drops immediately (asynchronously); queue contents are discarded; `drop_cnt` and `timeout_err` are cleared.

## Timing

- All outputs are registered except `desc_ready` = !full and `queue_level`, which are direct functions of registered state.
- **Issue latency:** a descriptor pushed at edge N, with the scheduler IDLE, enabled, and `rd_ctrl_rdy` = 1, produces `rd_ctrl` = 1 in the cycle after edge N+1, i.e. 2 cycles.
- **Back-to-back:** the minimum gap between successive `rd_ctrl` rises is 3 cycles (ISSUE → RUN → IDLE → ISSUE), assuming `rd_ctrl` accepts and completes within one cycle each.
- **Timeout boundary:** `timeout_err` is set at the edge where ISSUE has lasted `ACK_TIMEOUT` + 1 cycles without `rd_ctrl_rdy` falling.
- **Done latency:** `pkt_done` is high for exactly one cycle, the cycle following the edge at which `rd_ctrl_rdy` is sampled high in RUN.
- **Drop latency:** `drop_cnt` updates at the edge after the dropped `desc_valid`.

## Test plan

- **Single packet.** Push (0x0, 0x20); `rd_ctrl_rdy` model falls 1 cycle after `rd_ctrl`, rises 8 cycles later → `rd_ctrl` high 2 cycles after push, `pkt_begin` = 0, `pkt_end` = 0x20, `control` = 0, one `pkt_done`, `queue_level` returns to 0.
- **FIFO order and sequence numbers.** Push 3 descriptors back-to-back: (0x0, 0x20), (0x40, 0x80), (0x100, 0x104) → issued in that order with `control` = 0, 1, 2; 3 `pkt_done` pulses.
- **Full queue.** `enable` = 0; push `DEPTH` + 2 = 10 valid descriptors → `queue_level` = 8, `desc_ready` = 0, `drop_cnt` = 2. Then `enable` = 1 → exactly 8 issues.
- **Invalid descriptors.** Push (0x20, 0x20), (0x2, 0x10), (0x0, 0x1000) with `MAX_LEN` = 2048 → `drop_cnt` = 3, `rd_ctrl` never asserted.
- **Acceptance timeout.** `rd_ctrl_rdy` held at 1 throughout; push one descriptor → `rd_ctrl` high for 256 cycles, then low, `timeout_err` = 1, no `pkt_done`, next packet uses `control` = 1.
- **Reset mid-operation.** Assert `reset` while in RUN with 2 descriptors queued → `rd_ctrl`, `busy`, `queue_level` = 0 during reset; after release no issue occurs until a new push.
